store_narrow: RTL
=================

# store_narrow

Store-path narrowing unit for the multi-cycle MIPS datapath, performing the reverse of immediate/load extension. It accepts a 32-bit register value plus a byte address and writes a word (sw), halfword (sh) or byte (sb) into a single-port, word-wide data memory that has no byte enables. Sub-word stores are done as a read-modify-write sequenced by an internal FSM. It sits between the EX/MEM control and the data memory, with a valid/ready request handshake and a one-cycle completion pulse.

## Interface
- ADDR_W, 10, word-address width of the data memory
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_addr  in  32  byte address
- req_data  in  32  register data; sh uses [15:0], sb uses [7:0]
- Sop  in  2  00 sw, 01 sh, 10 sb, 11 reserved/illegal
- mem_addr  out  ADDR_W  word address = latched req_addr[ADDR_W+1:2]
- mem_rd  out  1  memory read strobe; data returned on mem_rdata the next cycle
- mem_rdata  in  32  memory read data
- mem_we  out  1  memory write strobe, sampled by memory at the next clk edge
- mem_wdata  out  32  full word to write
- done  out  1  one-cycle pulse: store committed
- err  out  1  one-cycle pulse: request rejected, no write

## Operation
- States: IDLE, READ, MERGE, WRITE.
- Request handshake:
  - A request is accepted on a clk edge where req_valid && req_ready.
  - req_addr, req_data and Sop are latched on acceptance and held until the return to IDLE.
- Legality check at acceptance:
  - Illegal cases: Sop=11; sh with addr[0]=1; sw with addr[1:0]!=0.
  - Illegal request: stay in IDLE, pulse err next cycle, no mem_rd or mem_we.
- sw: IDLE -> WRITE. mem_wdata = req_data.
- sh/sb: IDLE -> READ -> MERGE -> WRITE.
  - READ: mem_rd=1.
  - MERGE: mem_rdata is valid; the merged word is registered.
  - WRITE: mem_we=1, mem_wdata = merged word.
- Lane rules (little-endian):
  - sb writes req_data[7:0] into bits [8k+7:8k], k=addr[1:0].
  - sh writes req_data[15:0] into bits [16h+15:16h], h=addr[1].
  - All other bits come from mem_rdata unchanged.
- WRITE -> IDLE always. done pulses in the first IDLE cycle after WRITE.
- mem_addr is stable from acceptance through WRITE.
- mem_rd and mem_we are never high in the same cycle.
- req_valid while busy is ignored (req_ready=0). The requester holds it until accepted.
- Reset (asserted at any time, including mid-sequence):
  - FSM returns to IDLE immediately.
  - Any pending store is dropped with no write.
  - req_ready=1; mem_rd, mem_we, done, err = 0; mem_addr, mem_wdata = 0.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from req_* to mem_*.
- Cycle 0 is the accept edge.
  - sw: WRITE in cycle 1, done in cycle 2, next accept at the cycle-2 edge.
  - sh/sb: READ in cycle 1, MERGE in cycle 2, WRITE in cycle 3, done in cycle 4.
  - Illegal request: err in cycle 1, req_ready stays 1.
- Memory read latency is exactly one cycle: mem_rdata is sampled in MERGE only.
- Back-to-back requests: a new request can be accepted in the same cycle that done is high.

## Structure
- Package store_pkg holds:
  - Sop encodings: SOP_SW, SOP_SH, SOP_SB, SOP_ILL.
  - FSM state encoding (2 bits).
  - Byte-lane width constant (8).
- Sub-module lane_merge: purely combinational. Inputs are old word, new data, Sop and addr[1:0]; output is the merged word. It is reusable by the load-side extender's tests.
- The top level holds the FSM, the latched request registers and the registered outputs.

## Test plan
- sw aligned: addr 0x0000_0008, data 0xDEADBEEF -> mem_we in cycle 1 with mem_addr=2, wdata 0xDEADBEEF; done in cycle 2; mem_rd never asserted.
- sb lane 1: memory word 0x11223344, addr 0x0000_0005, data 0x000000AA -> mem_rd in cycle 1, mem_we in cycle 3 with wdata 0x1122AA44, done in cycle 4.
- sh upper half: memory word 0x11223344, addr 0x0000_0006, data 0xFFFFBEEF -> wdata 0xBEEF3344.
- Illegal requests: sh at addr 0x1, sw at addr 0x2, Sop=11 -> err pulse in cycle 1 each; no mem_rd or mem_we; done stays 0.
- Reset assertion during MERGE of an sb -> all outputs reset asynchronously; no mem_we ever; after release, req_ready=1 and a fresh sw completes normally.
- Back-to-back: sw then sb, with req_valid held high -> second request accepted on the done cycle; lane check as above.

Source files
------------

// File: rtl/store_narrow_pkg.sv
// Shared definitions for the store-path narrowing unit: store-op encodings,
// FSM state encoding, byte-lane width and the store legality rule.
package store_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        SOP_SW  = 2'b00,
        SOP_SH  = 2'b01,
        SOP_SB  = 2'b10,
        SOP_ILL = 2'b11
    } sop_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_MERGE = 2'b10,
        ST_WRITE = 2'b11
    } state_e;

    // A store is legal when its size matches the alignment of the byte address.
    function automatic logic is_legal_store(input sop_e sop, input logic [1:0] addr_lo);
        logic legal;
        case (sop)
            SOP_SW:  legal = (addr_lo == 2'b00);
            SOP_SH:  legal = (addr_lo[0] == 1'b0);
            SOP_SB:  legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/store_narrow_lane_merge.sv
// Combinational lane merge: inserts a byte or halfword of new data into an
// existing memory word at the little-endian lane chosen by the low address bits.
module lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  sop_e        sop,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    logic [31:0] merged_s;

    // Replace only the addressed lane; every other bit keeps the old word.
    always_comb begin
        merged_s = old_word;
        case (sop)
            SOP_SW: begin
                merged_s = new_data;
            end
            SOP_SH: begin
                if (addr_lo[1]) begin
                    merged_s[31:16] = new_data[15:0];
                end else begin
                    merged_s[15:0] = new_data[15:0];
                end
            end
            SOP_SB: begin
                merged_s[{addr_lo, 3'b000} +: BYTE_W] = new_data[BYTE_W-1:0];
            end
            default: begin
                merged_s = old_word;
            end
        endcase
    end

    assign merged = merged_s;

endmodule

// File: rtl/store_narrow.sv
// Store-path narrowing unit: writes sw directly and performs sh/sb as a
// read-modify-write on a word-wide memory without byte enables.
module store_narrow
    import store_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        Sop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    state_e            state_r;
    sop_e              sop_r;
    logic [1:0]        addr_lo_r;
    logic [31:0]       data_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_rd_r;
    logic              mem_we_r;
    logic [31:0]       mem_wdata_r;
    logic              done_r;
    logic              err_r;

    sop_e              req_sop_s;
    logic              legal_s;
    logic [31:0]       merged_s;
    // Byte address bits above the memory's reach do not take part in the store.
    logic              unused_addr_s;

    assign req_sop_s     = sop_e'(Sop);
    assign legal_s       = is_legal_store(req_sop_s, req_addr[1:0]);
    assign unused_addr_s = ^req_addr[31:ADDR_W+2];

    // Merge works from latched request fields, so memory data is the only live input.
    lane_merge u_lane_merge (
        .old_word (mem_rdata),
        .new_data (data_r),
        .sop      (sop_r),
        .addr_lo  (addr_lo_r),
        .merged   (merged_s)
    );

    // Store sequencer with registered request fields and memory/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            sop_r       <= SOP_SW;
            addr_lo_r   <= 2'b00;
            data_r      <= 32'h0000_0000;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_rd_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 32'h0000_0000;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            mem_rd_r <= 1'b0;
            mem_we_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        sop_r      <= req_sop_s;
                        addr_lo_r  <= req_addr[1:0];
                        data_r     <= req_data;
                        mem_addr_r <= req_addr[ADDR_W+1:2];
                        if (!legal_s) begin
                            err_r   <= 1'b1;
                            state_r <= ST_IDLE;
                        end else if (req_sop_s == SOP_SW) begin
                            mem_we_r    <= 1'b1;
                            mem_wdata_r <= req_data;
                            state_r     <= ST_WRITE;
                        end else begin
                            mem_rd_r <= 1'b1;
                            state_r  <= ST_READ;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    // Memory answers the read strobe one cycle later, in MERGE.
                    state_r <= ST_MERGE;
                end
                ST_MERGE: begin
                    mem_wdata_r <= merged_s;
                    mem_we_r    <= 1'b1;
                    state_r     <= ST_WRITE;
                end
                ST_WRITE: begin
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign mem_addr  = mem_addr_r;
    assign mem_rd    = mem_rd_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = mem_wdata_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule
